// File: rtl/alu_seq_ctrl_if.sv
// Command/response bus of the sequential ALU controller.
//
// Handshake rules, both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its
// payload steady until the transfer, and never withdraws valid early. A
// consumer may drive ready independently of valid.
interface alu_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs AND/OR/ADD/SUB/SLT/MUL on a shared external 32-bit ALU.
// One command in flight at a time; MUL is an unsigned shift-add multiply
// keeping the low 32 bits. dbg_state mirrors the FSM state register.
module alu_seq_ctrl #(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_less,
  output logic        alu_cin,
  output logic        alu_ainv,
  output logic        alu_binv,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [5:0] LAST_STEP = 6'(MUL_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    SLT2 = 3'd2,
    MUL  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] acc, mcand, mplier;
  logic [5:0]  step_q;
  logic        lt_q;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q, rsp_ovf_q, rsp_err_q;

  logic accept;
  logic illegal_op;
  logic mul_last;

  assign accept     = (state_q == IDLE) && bus.cmd_valid;
  assign illegal_op = (bus.cmd_op[2:1] == 2'b11);
  assign mul_last   = (step_q == LAST_STEP);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

  // State register; reset aborts whatever command is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and ALU drives; drives are zero except in EXEC/SLT2/MUL.
  always_comb begin
    state_d  = state_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_less = 32'd0;
    alu_cin  = 1'b0;
    alu_ainv = 1'b0;
    alu_binv = 1'b0;
    alu_op   = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == OP_MUL) state_d = MUL;
          else if (illegal_op)      state_d = RESP;
          else                      state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          OP_AND:  alu_op = 2'b00;
          OP_OR:   alu_op = 2'b01;
          default: alu_op = 2'b10;
        endcase
        // SUB and SLT both compute a - b as a + ~b + 1.
        if (op_q == OP_SUB || op_q == OP_SLT) begin
          alu_binv = 1'b1;
          alu_cin  = 1'b1;
        end
        state_d = (op_q == OP_SLT) ? SLT2 : RESP;
      end
      SLT2: begin
        alu_op   = 2'b11;
        alu_less = {31'd0, lt_q};
        state_d  = RESP;
      end
      MUL: begin
        alu_a  = acc;
        alu_b  = mplier[0] ? mcand : 32'd0;
        alu_op = 2'b10;
        if (mul_last) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, multiply datapath and response payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      acc        <= 32'd0;
      mcand      <= 32'd0;
      mplier     <= 32'd0;
      step_q     <= 6'd0;
      lt_q       <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_zero_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.cmd_op;
            a_q       <= bus.cmd_a;
            b_q       <= bus.cmd_b;
            step_q    <= 6'd0;
            rsp_err_q <= illegal_op;
            if (bus.cmd_op == OP_MUL) begin
              acc    <= 32'd0;
              mcand  <= bus.cmd_a;
              mplier <= bus.cmd_b;
            end
            // Illegal opcodes go straight to RESP with an empty payload.
            if (illegal_op) begin
              rsp_data_q <= 32'd0;
              rsp_zero_q <= 1'b0;
              rsp_ovf_q  <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (op_q == OP_SLT) begin
            // Signed less-than: sign of the difference corrected by overflow.
            lt_q <= alu_y[31] ^ alu_ovf;
          end else begin
            rsp_data_q <= alu_y;
            rsp_zero_q <= alu_zero;
            rsp_ovf_q  <= alu_ovf;
          end
        end
        SLT2: begin
          rsp_data_q <= alu_y;
          rsp_zero_q <= alu_zero;
          rsp_ovf_q  <= 1'b0;
        end
        MUL: begin
          acc    <= alu_y;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step_q <= step_q + 6'd1;
          // The final partial sum is the product; capture it directly.
          if (mul_last) begin
            rsp_data_q <= alu_y;
            rsp_zero_q <= (alu_y == 32'd0);
            rsp_ovf_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: directed commands against a behavioural
// shared ALU, with an expected-response queue checked by a monitor.
module tb_alu_seq_ctrl;

  // Expected entry: {accept_cycle[15:0], latency[7:0], zero_chk, err, ovf, zero, data[31:0]}
  localparam int W = 60;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_less, alu_y;
  logic        alu_cin, alu_ainv, alu_binv, alu_zero, alu_ovf;
  logic [1:0]  alu_op;
  logic [2:0]  dbg_state;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.MUL_STEPS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_less  (alu_less),
    .alu_cin   (alu_cin),
    .alu_ainv  (alu_ainv),
    .alu_binv  (alu_binv),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared ALU model ----------------
  logic [31:0] m_a, m_b, m_sum;
  always_comb begin
    m_a   = alu_ainv ? ~alu_a : alu_a;
    m_b   = alu_binv ? ~alu_b : alu_b;
    m_sum = m_a + m_b + {31'd0, alu_cin};
    case (alu_op)
      2'b00:   alu_y = m_a & m_b;
      2'b01:   alu_y = m_a | m_b;
      2'b10:   alu_y = m_sum;
      default: alu_y = alu_less;
    endcase
    alu_ovf  = (alu_op == 2'b10) && (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    alu_zero = (alu_y == 32'd0);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic [31:0] h_data;
  logic        h_zero, h_ovf, h_err;
  int          resp_count = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int lat;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (alu_op != 2'b11) check("alu_less_zero", {32'd0, alu_less}, 64'd0);
      if (bus.rsp_valid) begin
        check("cmd_ready_in_resp", {63'd0, bus.cmd_ready}, 64'd0);
        check("alu_ab_in_resp", {alu_a, alu_b}, 64'd0);
        check("alu_ctl_in_resp", {59'd0, alu_cin, alu_ainv, alu_binv, alu_op}, 64'd0);
        if (!prev_valid) begin
          resp_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got data %0h with no command pending", bus.rsp_data);
          end else begin
            e = exp_q.pop_front();
            lat = cyc - int'(e[59:44]) + 1;
            check("rsp_data", {32'd0, bus.rsp_data}, {32'd0, e[31:0]});
            check("rsp_ovf", {63'd0, bus.rsp_ovf}, {63'd0, e[33]});
            check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e[34]});
            if (e[35]) check("rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, e[32]});
            check("rsp_latency", 64'(lat), {56'd0, e[43:36]});
          end
          h_data = bus.rsp_data;
          h_zero = bus.rsp_zero;
          h_ovf  = bus.rsp_ovf;
          h_err  = bus.rsp_err;
        end else begin
          check("rsp_hold", {29'd0, bus.rsp_err, bus.rsp_ovf, bus.rsp_zero, bus.rsp_data},
                {29'd0, h_err, h_ovf, h_zero, h_data});
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] data, input logic zero, input logic ovf,
                      input logic err, input logic zchk, input logic [7:0] lat);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b, required 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      exp_q.push_back({16'(cyc), lat, zchk, err, ovf, zero, data});
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid || !bus.cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] data, input logic zero, input logic ovf,
                     input logic err, input logic zchk, input logic [7:0] lat);
    send(op, a, b, data, zero, ovf, err, zchk, lat);
    wait_drained();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rc;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.rsp_ready = 1'b1;

    #12;
    check("reset_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("reset_rsp_payload", {29'd0, bus.rsp_err, bus.rsp_ovf, bus.rsp_zero, bus.rsp_data}, 64'd0);
    check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    check("reset_alu_ctl", {27'd0, alu_less, alu_cin, alu_ainv, alu_binv, alu_op}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   op      a              b              data           z  o  e  zc lat
    run(3'b010, 32'd1,         32'd5,         32'd6,         0, 0, 0, 1, 8'd2);
    run(3'b011, 32'd5,         32'd5,         32'd0,         1, 0, 0, 1, 8'd2);
    run(3'b011, 32'h80000000,  32'd1,         32'h7FFFFFFF,  0, 1, 0, 1, 8'd2);
    run(3'b100, 32'hFFFFFFFF,  32'd1,         32'd1,         0, 0, 0, 1, 8'd3);
    run(3'b100, 32'd1,         32'hFFFFFFFF,  32'd0,         1, 0, 0, 1, 8'd3);
    run(3'b100, 32'h80000000,  32'd1,         32'd1,         0, 0, 0, 1, 8'd3);
    run(3'b100, 32'd5,         32'd3,         32'd0,         1, 0, 0, 1, 8'd3);
    run(3'b101, 32'd7,         32'd6,         32'd42,        0, 0, 0, 1, 8'd33);
    run(3'b101, 32'h00010000,  32'h00010000,  32'd0,         1, 0, 0, 1, 8'd33);
    run(3'b101, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         0, 0, 0, 1, 8'd33);
    run(3'b000, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  0, 0, 0, 1, 8'd2);
    run(3'b001, 32'h12340000,  32'h00005678,  32'h12345678,  0, 0, 0, 1, 8'd2);
    run(3'b001, 32'd0,         32'd0,         32'd0,         1, 0, 0, 1, 8'd2);
    run(3'b010, 32'h7FFFFFFF,  32'd1,         32'h80000000,  0, 1, 0, 1, 8'd2);
    run(3'b111, 32'd9,         32'd9,         32'd0,         0, 0, 1, 0, 8'd1);
    run(3'b110, 32'd1,         32'd2,         32'd0,         0, 0, 1, 0, 8'd1);

    // Back-pressure: response must hold steady while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    send(3'b010, 32'd10, 32'd20, 32'd30, 0, 0, 0, 1, 8'd2);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    repeat (5) @(negedge clk);
    check("stall_still_valid", {63'd0, bus.rsp_valid}, 64'd1);
    bus.rsp_ready = 1'b1;
    wait_drained();

    // Reset during MUL cycle 10: no response may ever appear.
    send(3'b101, 32'd3, 32'd4, 32'd12, 0, 0, 0, 1, 8'd33);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    rc = resp_count;
    #1;
    check("abort_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_no_response", 64'(resp_count), 64'(rc));
    run(3'b010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1, 8'd2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_STEPS, default 32, giving the number of shift-add iterations per MUL, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit, command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit, command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 The block SHALL have port cmd_op, input, 3 bits, the opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL, 110/111 illegal.
REQ-007 The block SHALL have ports cmd_a and cmd_b, input, 32 bits each, the operands.
REQ-008 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-009 The block SHALL have ports rsp_data (output, 32), rsp_zero (output, 1), rsp_ovf (output, 1) and rsp_err (output, 1), the response payload.
REQ-010 The block SHALL have ALU-side outputs alu_a (32), alu_b (32), alu_less (32), alu_cin (1), alu_ainv (1), alu_binv (1) and alu_op (2), where alu_op 00 is AND, 01 OR, 10 ADD and 11 selects alu_less.
REQ-011 The block SHALL have ALU-side inputs alu_y (32), alu_zero (1) and alu_ovf (1), combinational results from the shared 32-bit ALU.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC, SLT2, MUL and RESP.
REQ-013 cmd_ready SHALL be high only in IDLE, with at most one command outstanding.
REQ-014 On accept, the block SHALL register the opcode and operands and move to MUL for opcode 101, to RESP with rsp_err=1 and rsp_data=0 for opcodes 110/111, and to EXEC otherwise.
REQ-015 In EXEC, the ALU drives SHALL be: AND/OR → op 00/01, cin=0, binv=0; ADD → op 10, cin=0; SUB and SLT → op 10, binv=1, cin=1; ainv=0 in all cases.
REQ-016 At the end of EXEC, AND/OR/ADD/SUB SHALL capture alu_y, alu_zero and alu_ovf into the response and move to RESP, so that rsp_valid rises 2 edges after accept.
REQ-017 At the end of EXEC, SLT SHALL latch lt = alu_y[31] XOR alu_ovf and move to SLT2.
REQ-018 In SLT2, the block SHALL drive alu_op=11 and alu_less={31'b0,lt}, then capture alu_y and alu_zero with rsp_ovf=0, so that rsp_valid rises 3 edges after accept.
REQ-019 MUL (unsigned, low 32 bits) SHALL initialise acc=0, mcand=cmd_a and mplier=cmd_b on accept.
REQ-020 Each MUL cycle SHALL drive alu_a=acc, alu_b = mplier[0] ? mcand : 0, op 10, cin=0, and at the edge load acc←alu_y, mcand←mcand<<1, mplier←mplier>>1.
REQ-021 After MUL_STEPS cycles the block SHALL present rsp_data=acc, rsp_zero=(acc==0), rsp_ovf=0, so that rsp_valid rises MUL_STEPS+1 edges after accept; bits shifted out are discarded.
REQ-022 In RESP, rsp_valid SHALL be 1 and the payload held stable until rsp_ready=1 at an edge, then the FSM returns to IDLE; rsp_ready is ignored outside RESP.
REQ-023 A command SHALL NOT be accepted in the same cycle a response completes; cmd_ready rises the cycle after.
REQ-024 ALU drives in IDLE and RESP SHALL be all-zero, alu_op=00.
REQ-025 alu_less SHALL be 0 in every state except SLT2.
REQ-026 rsp_err SHALL be 0 for legal opcodes.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE with cmd_ready=1, rsp_valid=0, and rsp_data, rsp_zero, rsp_ovf, rsp_err, acc, mcand, mplier, the latched lt and all ALU drives at 0.
REQ-028 Reset asserted mid-operation (EXEC/SLT2/MUL/RESP) SHALL abort immediately with no response ever issued for the aborted command.

Verification
REQ-029 ADD a=1, b=5, rsp_ready=1 → rsp_valid 2 edges after accept, data=6, zero=0, ovf=0.
REQ-030 SUB a=5, b=5 → data=0, zero=1; SUB a=32'h80000000, b=1 → data=32'h7FFFFFFF, ovf=1.
REQ-031 SLT a=32'hFFFFFFFF, b=1 → data=1 at 3 edges after accept; SLT a=1, b=32'hFFFFFFFF → data=0, zero=1.
REQ-032 MUL a=7, b=6 → data=42 exactly 33 edges after accept; MUL a=32'h10000, b=32'h10000 → data=0, zero=1.
REQ-033 Hold rsp_ready=0 for 5 cycles → payload stable, cmd_ready=0 throughout; opcode 111 → rsp_err=1, data=0.
REQ-034 Drop rst_n at MUL cycle 10 → rsp_valid never asserts, cmd_ready=1 immediately; a following ADD 2+3 → data=5.
